// File: rtl/sprite_obstacle_lane_if.sv
// Pixel-stream and control bundle between the frame controller (master)
// and one obstacle lane sprite (slave).
interface sprite_obstacle_lane_if;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic        i_v_sync;
  logic        i_spawn;
  logic        i_freeze;
  logic [7:0]  o_red;
  logic [7:0]  o_green;
  logic [7:0]  o_blue;
  logic        o_sprite_hit;
  logic        o_active;
  logic [15:0] o_sprite_y;

  modport master (
    output i_x, i_y, i_v_sync, i_spawn, i_freeze,
    input  o_red, o_green, o_blue, o_sprite_hit, o_active, o_sprite_y
  );

  modport slave (
    input  i_x, i_y, i_v_sync, i_spawn, i_freeze,
    output o_red, o_green, o_blue, o_sprite_hit, o_active, o_sprite_y
  );
endinterface

// File: rtl/sprite_obstacle_lane.sv
// One 32x32 obstacle moving down a perspective lane, scaled x1/x2/x4 with depth,
// with registered colour, collision, visibility and y outputs.
module sprite_obstacle_lane #(
  parameter int          START_X        = 640,
  parameter int          X_DIR          = 1,
  parameter int          Y_END          = 592,
  parameter int          SCALE2_Y       = 300,
  parameter int          SCALE4_Y       = 450,
  parameter int          HIT_Y_MIN      = 144,
  parameter int          SPEED          = 1,
  parameter int          RESPAWN_FRAMES = 450,
  parameter int          AUTO_RESPAWN   = 1,
  parameter logic [23:0] FILL_RGB       = 24'h680100
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  sprite_obstacle_lane_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [15:0] START_X_C   = 16'(START_X);
  localparam logic [15:0] Y_END_C     = 16'(Y_END);
  localparam logic [16:0] Y_END_17    = 17'(Y_END);
  localparam logic [15:0] SCALE2_C    = 16'(SCALE2_Y);
  localparam logic [15:0] SCALE4_C    = 16'(SCALE4_Y);
  localparam logic [15:0] HIT_MIN_C   = 16'(HIT_Y_MIN);
  localparam logic [16:0] SPEED_17    = 17'(SPEED);
  localparam logic [15:0] RESPAWN_C   = 16'(RESPAWN_FRAMES);

  // Ring obstacle bitmap: outer black rim, fill body, black-rimmed hole, rows 10..20 only.
  function automatic logic [1:0] rom_index(input logic [4:0] row, input logic [4:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    if (row < 5'd10 || row > 5'd20) begin
      idx = 2'd0;
    end else if (col == 5'd0 || col == 5'd31) begin
      idx = 2'd1;
    end else if (row == 5'd10 || row == 5'd20) begin
      idx = 2'd2;
    end else if (col < 5'd9 || col > 5'd22) begin
      idx = 2'd2;
    end else if (row == 5'd11 || row == 5'd19 || col == 5'd9 || col == 5'd22) begin
      idx = 2'd1;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

  function automatic logic [23:0] palette(input logic [1:0] idx);
    logic [23:0] rgb;
    case (idx)
      2'd2:    rgb = FILL_RGB;
      2'd1:    rgb = 24'h000000;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] y_r, y_s;
  logic [15:0] cnt_r, cnt_s;
  logic [15:0] x_r, x_s;
  logic        vs_prev_r;
  logic        tick_s;
  logic        step_s;
  logic [16:0] y_inc_s;
  logic [15:0] cnt_inc_s;
  logic [1:0]  shift_s;
  logic [15:0] half_s;
  logic [15:0] base_s;

  logic [16:0] size_s;
  logic [16:0] px_17_s, py_17_s, x_17_s, y_17_s;
  logic        inside_s;
  logic [6:0]  dx_s, dy_s;
  logic [4:0]  col_s, row_s;
  logic [1:0]  idx_s;
  logic [23:0] rgb_s;
  logic        hit_s;

  logic [23:0] rgb_r;
  logic        hit_r;
  logic        active_r;
  logic [15:0] sprite_y_r;

  assign tick_s = bus.i_v_sync & ~vs_prev_r;
  assign step_s = tick_s & ~bus.i_freeze;

  // Previous v_sync sample; resets high so reset release never looks like an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vs_prev_r <= 1'b1;
    end else begin
      vs_prev_r <= bus.i_v_sync;
    end
  end

  // State, y and hold counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      y_r     <= 16'd0;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      y_r     <= y_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; a spawn request overrides any same-cycle frame tick.
  always_comb begin
    state_s   = state_r;
    y_s       = y_r;
    cnt_s     = cnt_r;
    y_inc_s   = {1'b0, y_r} + SPEED_17;
    cnt_inc_s = cnt_r + 16'd1;
    if (bus.i_spawn) begin
      state_s = ST_MOVE;
      y_s     = 16'd0;
      cnt_s   = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_MOVE: begin
          if (step_s) begin
            if (y_inc_s >= Y_END_17) begin
              state_s = ST_HOLD;
              y_s     = Y_END_C;
              cnt_s   = 16'd0;
            end else begin
              y_s = y_inc_s[15:0];
            end
          end else begin
            y_s = y_r;
          end
        end
        ST_HOLD: begin
          if (step_s) begin
            if (cnt_inc_s == RESPAWN_C) begin
              cnt_s = 16'd0;
              if (AUTO_RESPAWN != 0) begin
                state_s = ST_MOVE;
                y_s     = 16'd0;
              end else begin
                state_s = ST_IDLE;
              end
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
          y_s     = 16'd0;
          cnt_s   = 16'd0;
        end
      endcase
    end
  end

  // Depth scale (as a shift) and lane x; boundaries belong to the larger scale.
  always_comb begin
    if (y_r < SCALE2_C) begin
      shift_s = 2'd0;
    end else if (y_r < SCALE4_C) begin
      shift_s = 2'd1;
    end else begin
      shift_s = 2'd2;
    end
    half_s = {1'b0, y_r[15:1]};
    if (X_DIR > 0) begin
      base_s = START_X_C + half_s;
    end else if (X_DIR < 0) begin
      base_s = START_X_C - half_s;
    end else begin
      base_s = START_X_C;
    end
    x_s = base_s - (16'd16 << shift_s);
  end

  // x follows y one cycle later, well before the next active line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_r <= START_X_C - 16'd16;
    end else begin
      x_r <= x_s;
    end
  end

  // Bounding-box test at 17 bits, then bitmap lookup at the scaled address.
  always_comb begin
    size_s   = 17'd32 << shift_s;
    px_17_s  = {1'b0, bus.i_x};
    py_17_s  = {1'b0, bus.i_y};
    x_17_s   = {1'b0, x_r};
    y_17_s   = {1'b0, y_r};
    inside_s = (px_17_s >= x_17_s) && (px_17_s < x_17_s + size_s) &&
               (py_17_s >= y_17_s) && (py_17_s < y_17_s + size_s);
    dx_s     = bus.i_x[6:0] - x_r[6:0];
    dy_s     = bus.i_y[6:0] - y_r[6:0];
    case (shift_s)
      2'd1: begin
        col_s = dx_s[5:1];
        row_s = dy_s[5:1];
      end
      2'd2: begin
        col_s = dx_s[6:2];
        row_s = dy_s[6:2];
      end
      default: begin
        col_s = dx_s[4:0];
        row_s = dy_s[4:0];
      end
    endcase
    idx_s = rom_index(row_s, col_s);
    if (inside_s && state_r != ST_IDLE) begin
      rgb_s = palette(idx_s);
    end else begin
      rgb_s = 24'h000000;
    end
    hit_s = inside_s && (idx_s != 2'd0) && (state_r == ST_MOVE) &&
            (y_r >= HIT_MIN_C) && (y_r < Y_END_C);
  end

  // Registered pixel, collision and status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rgb_r      <= 24'h000000;
      hit_r      <= 1'b0;
      active_r   <= 1'b0;
      sprite_y_r <= 16'd0;
    end else begin
      rgb_r      <= rgb_s;
      hit_r      <= hit_s;
      active_r   <= (state_s != ST_IDLE);
      sprite_y_r <= y_s;
    end
  end

  assign bus.o_red        = rgb_r[23:16];
  assign bus.o_green      = rgb_r[15:8];
  assign bus.o_blue       = rgb_r[7:0];
  assign bus.o_sprite_hit = hit_r;
  assign bus.o_active     = active_r;
  assign bus.o_sprite_y   = sprite_y_r;

endmodule

// File: tb/tb_sprite_obstacle_lane.sv
// Directed bench: two lanes (right-drifting auto-respawn, left-drifting one-shot)
// driven with identical stimulus and checked against hand-computed values.
module tb_sprite_obstacle_lane;

  localparam logic [23:0] FILL = 24'h680100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] px, py;
  logic        vsync, spawn, freeze;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sprite_obstacle_lane_if bus_a ();
  sprite_obstacle_lane_if bus_b ();

  assign bus_a.i_x      = px;
  assign bus_a.i_y      = py;
  assign bus_a.i_v_sync = vsync;
  assign bus_a.i_spawn  = spawn;
  assign bus_a.i_freeze = freeze;
  assign bus_b.i_x      = px;
  assign bus_b.i_y      = py;
  assign bus_b.i_v_sync = vsync;
  assign bus_b.i_spawn  = spawn;
  assign bus_b.i_freeze = freeze;

  wire [23:0] rgb_a = {bus_a.o_red, bus_a.o_green, bus_a.o_blue};
  wire [23:0] rgb_b = {bus_b.o_red, bus_b.o_green, bus_b.o_blue};

  sprite_obstacle_lane dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  sprite_obstacle_lane #(.X_DIR(-1), .AUTO_RESPAWN(0)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
    end
  endtask

  task automatic probe(input logic [15:0] xx, input logic [15:0] yy);
    px = xx;
    py = yy;
    step();
  endtask

  task automatic pulse_spawn();
    spawn = 1'b1;
    step();
    spawn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    ticks(10);
    probe(16'd626, 16'd10);
    checks++; if (bus_a.o_active !== 1'b0) begin errors++; $display("FAIL reset_active_a: got %0b expected 0", bus_a.o_active); end
    checks++; if (bus_b.o_active !== 1'b0) begin errors++; $display("FAIL reset_active_b: got %0b expected 0", bus_b.o_active); end
    checks++; if (rgb_a !== 24'h000000) begin errors++; $display("FAIL reset_rgb_a: got %h expected 000000", rgb_a); end
    checks++; if (bus_a.o_sprite_y !== 16'd0) begin errors++; $display("FAIL reset_y_a: got %0d expected 0", bus_a.o_sprite_y); end
    checks++; if (bus_a.o_sprite_hit !== 1'b0) begin errors++; $display("FAIL reset_hit_a: got %0b expected 0", bus_a.o_sprite_hit); end
  endtask

  task automatic test_scale_position();
    pulse_spawn();
    ticks(299);
    checks++; if (bus_a.o_sprite_y !== 16'd299) begin errors++; $display("FAIL y299_a: got %0d expected 299", bus_a.o_sprite_y); end
    checks++; if (bus_a.o_active !== 1'b1) begin errors++; $display("FAIL move_active_a: got %0b expected 1", bus_a.o_active); end
    probe(16'd775, 16'd309);
    checks++; if (rgb_a !== FILL) begin errors++; $display("FAIL s1_fill_a: got %h expected %h", rgb_a, FILL); end
    checks++; if (bus_a.o_sprite_hit !== 1'b1) begin errors++; $display("FAIL s1_hit_a: got %0b expected 1", bus_a.o_sprite_hit); end
    probe(16'd772, 16'd309);
    checks++; if (rgb_a !== 24'h000000) begin errors++; $display("FAIL s1_left_edge_a: got %h expected 000000", rgb_a); end
    probe(16'd477, 16'd309);
    checks++; if (rgb_b !== FILL) begin errors++; $display("FAIL s1_fill_b: got %h expected %h", rgb_b, FILL); end
    ticks(1);
    checks++; if (bus_a.o_sprite_y !== 16'd300) begin errors++; $display("FAIL y300_a: got %0d expected 300", bus_a.o_sprite_y); end
    probe(16'd762, 16'd320);
    checks++; if (rgb_a !== FILL) begin errors++; $display("FAIL s2_fill_a: got %h expected %h", rgb_a, FILL); end
    probe(16'd757, 16'd320);
    checks++; if (rgb_a !== 24'h000000) begin errors++; $display("FAIL s2_left_edge_a: got %h expected 000000", rgb_a); end
    probe(16'd758, 16'd320);
    checks++; if (rgb_a !== 24'h000000) begin errors++; $display("FAIL s2_black_rgb_a: got %h expected 000000", rgb_a); end
    checks++; if (bus_a.o_sprite_hit !== 1'b1) begin errors++; $display("FAIL s2_black_hit_a: got %0b expected 1", bus_a.o_sprite_hit); end
  endtask

  task automatic test_scale4();
    ticks(149);
    probe(16'd388, 16'd469);
    checks++; if (rgb_b !== FILL) begin errors++; $display("FAIL y449_s2_fill_b: got %h expected %h", rgb_b, FILL); end
    ticks(1);
    probe(16'd359, 16'd490);
    checks++; if (bus_b.o_red !== 8'h68) begin errors++; $display("FAIL s4_red_b: got %h expected 68", bus_b.o_red); end
    checks++; if (bus_b.o_green !== 8'h01) begin errors++; $display("FAIL s4_green_b: got %h expected 01", bus_b.o_green); end
    checks++; if (bus_b.o_blue !== 8'h00) begin errors++; $display("FAIL s4_blue_b: got %h expected 00", bus_b.o_blue); end
    probe(16'd809, 16'd490);
    checks++; if (rgb_a !== FILL) begin errors++; $display("FAIL s4_fill_a: got %h expected %h", rgb_a, FILL); end
  endtask

  task automatic test_hold_respawn();
    ticks(142);
    checks++; if (bus_a.o_sprite_y !== 16'd592) begin errors++; $display("FAIL park_y_a: got %0d expected 592", bus_a.o_sprite_y); end
    checks++; if (bus_b.o_sprite_y !== 16'd592) begin errors++; $display("FAIL park_y_b: got %0d expected 592", bus_b.o_sprite_y); end
    probe(16'd880, 16'd632);
    checks++; if (rgb_a !== FILL) begin errors++; $display("FAIL hold_fill_a: got %h expected %h", rgb_a, FILL); end
    checks++; if (bus_a.o_sprite_hit !== 1'b0) begin errors++; $display("FAIL hold_hit_a: got %0b expected 0", bus_a.o_sprite_hit); end
    probe(16'd288, 16'd632);
    checks++; if (rgb_b !== FILL) begin errors++; $display("FAIL hold_fill_b: got %h expected %h", rgb_b, FILL); end
    checks++; if (bus_b.o_sprite_hit !== 1'b0) begin errors++; $display("FAIL hold_hit_b: got %0b expected 0", bus_b.o_sprite_hit); end
    ticks(449);
    checks++; if (bus_a.o_sprite_y !== 16'd592) begin errors++; $display("FAIL hold449_y_a: got %0d expected 592", bus_a.o_sprite_y); end
    checks++; if (bus_b.o_active !== 1'b1) begin errors++; $display("FAIL hold449_active_b: got %0b expected 1", bus_b.o_active); end
    ticks(1);
    checks++; if (bus_a.o_sprite_y !== 16'd0) begin errors++; $display("FAIL respawn_y_a: got %0d expected 0", bus_a.o_sprite_y); end
    checks++; if (bus_a.o_active !== 1'b1) begin errors++; $display("FAIL respawn_active_a: got %0b expected 1", bus_a.o_active); end
    checks++; if (bus_b.o_active !== 1'b0) begin errors++; $display("FAIL oneshot_idle_b: got %0b expected 0", bus_b.o_active); end
    probe(16'd288, 16'd632);
    checks++; if (rgb_b !== 24'h000000) begin errors++; $display("FAIL idle_rgb_b: got %h expected 000000", rgb_b); end
  endtask

  task automatic test_spawn_tick();
    pulse_spawn();
    ticks(200);
    checks++; if (bus_a.o_sprite_y !== 16'd200) begin errors++; $display("FAIL y200_a: got %0d expected 200", bus_a.o_sprite_y); end
    spawn = 1'b1;
    vsync = 1'b1;
    step();
    checks++; if (bus_a.o_sprite_y !== 16'd0) begin errors++; $display("FAIL spawn_wins_a: got %0d expected 0", bus_a.o_sprite_y); end
    checks++; if (bus_b.o_sprite_y !== 16'd0) begin errors++; $display("FAIL spawn_wins_b: got %0d expected 0", bus_b.o_sprite_y); end
    spawn = 1'b0;
    vsync = 1'b0;
    step();
  endtask

  task automatic test_freeze();
    ticks(100);
    checks++; if (bus_a.o_sprite_y !== 16'd100) begin errors++; $display("FAIL y100_a: got %0d expected 100", bus_a.o_sprite_y); end
    freeze = 1'b1;
    ticks(20);
    checks++; if (bus_a.o_sprite_y !== 16'd100) begin errors++; $display("FAIL frozen_y_a: got %0d expected 100", bus_a.o_sprite_y); end
    checks++; if (bus_b.o_sprite_y !== 16'd100) begin errors++; $display("FAIL frozen_y_b: got %0d expected 100", bus_b.o_sprite_y); end
    freeze = 1'b0;
    ticks(1);
    checks++; if (bus_a.o_sprite_y !== 16'd101) begin errors++; $display("FAIL unfrozen_y_a: got %0d expected 101", bus_a.o_sprite_y); end
  endtask

  task automatic test_mid_reset();
    probe(16'd676, 16'd111);
    checks++; if (rgb_a !== FILL) begin errors++; $display("FAIL pre_reset_fill_a: got %h expected %h", rgb_a, FILL); end
    rst_n = 1'b0;
    step();
    checks++; if (rgb_a !== 24'h000000) begin errors++; $display("FAIL mid_reset_rgb_a: got %h expected 000000", rgb_a); end
    checks++; if (bus_a.o_active !== 1'b0) begin errors++; $display("FAIL mid_reset_active_a: got %0b expected 0", bus_a.o_active); end
    checks++; if (bus_a.o_sprite_y !== 16'd0) begin errors++; $display("FAIL mid_reset_y_a: got %0d expected 0", bus_a.o_sprite_y); end
    rst_n = 1'b1;
    step();
    checks++; if (rgb_a !== 24'h000000) begin errors++; $display("FAIL post_reset_rgb_a: got %h expected 000000", rgb_a); end
  endtask

  initial begin
    rst_n  = 1'b0;
    px     = 16'd0;
    py     = 16'd0;
    vsync  = 1'b0;
    spawn  = 1'b0;
    freeze = 1'b0;
    test_reset();
    test_scale_position();
    test_scale4();
    test_hold_respawn();
    test_spawn_tick();
    test_freeze();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_obstacle_lane.md
Name: sprite_obstacle_lane

Overview:
- Parametrised, clocked successor to the fixed single-lane obstacle sprite.
- Moves one 32x32, 2-bit-palette obstacle down a perspective lane: left, centre or right, selected by parameter. Scales x1/x2/x4 with depth.
- Spawn/respawn is under game-controller command; the obstacle can optionally auto-respawn.
- Per-pixel colour and collision outputs are registered and feed the top-level compositor and collision logic.

Parameters:
- START_X, 640, lane x at y=0, in pixels.
- X_DIR, 1, lane slope: +1 drifts right, -1 drifts left, 0 straight down; x moves by y>>1.
- Y_END, 592, parking y: the bottom of the visible track.
- SCALE2_Y, 300, first y at which the scale is x2.
- SCALE4_Y, 450, first y at which the scale is x4.
- HIT_Y_MIN, 144, lowest y at which collision is reported.
- SPEED, 1, y increment per frame.
- RESPAWN_FRAMES, 450, frames held at Y_END before respawn.
- AUTO_RESPAWN, 1, 1 = restart automatically after hold; 0 = return to IDLE.
- FILL_RGB, 24'h680100, palette index 2 colour; index 1 is black; index 0 is transparent.

Ports:
- i_clk, in, 1, pixel clock.
- i_rst_n, in, 1, synchronous active-low reset.
- i_x, in, 16, current pixel x.
- i_y, in, 16, current pixel y.
- i_v_sync, in, 1, vertical sync, synchronous to i_clk.
- i_spawn, in, 1, one-cycle pulse requesting spawn.
- i_freeze, in, 1, level; when high, motion and hold counting are suspended.
- o_red, out, 8, pixel red.
- o_green, out, 8, pixel green.
- o_blue, out, 8, pixel blue.
- o_sprite_hit, out, 1, opaque obstacle pixel inside the collision band.
- o_active, out, 1, obstacle is visible (state MOVE or HOLD).
- o_sprite_y, out, 16, current obstacle y.

Behaviour:
- Reset (i_rst_n low at a rising edge of i_clk):
  - state = IDLE, y = 0, hold counter = 0, x = START_X - 16.
  - All colour outputs, o_sprite_hit and o_active = 0.
- Frame tick: one-cycle pulse on a rising edge of i_v_sync, detected against a registered previous sample. The previous sample resets to 1, so there is no spurious tick after reset.
- States:
  - IDLE: invisible. i_spawn -> MOVE, with y = 0.
  - MOVE: on each tick with i_freeze low, y += SPEED. If y+SPEED >= Y_END, y saturates to Y_END and the state goes to HOLD with counter = 0.
  - HOLD: on each tick with i_freeze low, counter += 1. When the counter reaches RESPAWN_FRAMES:
    - if AUTO_RESPAWN=1: go to MOVE with y = 0;
    - if AUTO_RESPAWN=0: go to IDLE.
  - i_spawn in MOVE or HOLD restarts immediately: MOVE, y = 0, counter = 0.
  - If i_spawn and a tick arrive in the same cycle, i_spawn wins.
- Scale s:
  - s = 1 if y < SCALE2_Y;
  - s = 2 if SCALE2_Y <= y < SCALE4_Y;
  - s = 4 if y >= SCALE4_Y.
  - Boundaries belong to the larger scale.
- Position: x = START_X + X_DIR*(y>>1) - 16*s, using 16-bit unsigned arithmetic with wrap.
  - x is registered and updated in the cycle after y changes, so x and y are consistent before the next active line.
- Pixel path (1-cycle latency; outputs correspond to i_x/i_y of the previous cycle):
  - inside = i_x in [x, x+32*s) and i_y in [y, y+32*s), with the comparisons evaluated 17 bits wide so they do not overflow.
  - Bitmap address = ((i_y-y)>>log2 s, (i_x-x)>>log2 s), each 5 bits.
  - ROM holds a 32x32 array of 2-bit indices; the ring-shaped obstacle occupies rows 10..20.
  - Colour = palette[index] when inside and state != IDLE; otherwise 0. A transparent pixel outputs 0.
  - o_sprite_hit = inside && index != 0 && state == MOVE && y >= HIT_Y_MIN && y < Y_END.
  - No hits are reported during HOLD.
- o_sprite_y and o_active are registered and update with the state.
- Reset mid-frame takes effect on the next clock; the pixel outputs read 0 in the following cycle.

Test Plan:
- Reset then no spawn, 10 v_sync pulses -> o_active=0, all colour outputs 0, o_sprite_y=0.
- i_spawn, then 299 ticks -> o_sprite_y=299, s=1, x=640+149-16=773. One more tick -> y=300, s=2, x=640+150-32=758.
- X_DIR=-1, y=450 -> s=4, x=640-225-64=351. Pixel (351+8, 450+40) maps to bitmap (10,2): index 2 -> RGB 68/01/00 one cycle later.
- Run to Y_END=592 -> HOLD, o_sprite_hit stays 0 over opaque pixels. After 450 ticks, with AUTO_RESPAWN=1 -> y=0, MOVE; with AUTO_RESPAWN=0 -> IDLE, o_active=0.
- At y=200 in MOVE, i_spawn coincident with a tick -> y=0, not 201.
- i_freeze high for 20 ticks at y=100 -> y stays 100. Drop i_rst_n for one cycle -> IDLE, outputs 0 on the next cycle.
